// File: rtl/rst_pkg.sv
// rtl/rst_pkg.sv - shared reset-logic types and sizing helpers
// Contents:
//   rst_state_e    : key FSM state encoding (IDLE=0, DEB_PRESS=1, HOLD=2, WAIT_REL=3)
//   clog2()        : bits needed to hold values 0..value-1
//   max_int()      : larger of two integers
//   EVENT_CNT_W/MAX: width and saturation value of the press counter
package rst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DEB_PRESS = 2'd1,
    ST_HOLD      = 2'd2,
    ST_WAIT_REL  = 2'd3
  } rst_state_e;

  localparam int EVENT_CNT_W = 8;
  localparam logic [EVENT_CNT_W-1:0] EVENT_CNT_MAX = 8'hFF;

  function automatic int clog2(input int value);
    int v;
    int w;
    v = value - 1;
    w = 0;
    while (v > 0) begin
      w = w + 1;
      v = v >> 1;
    end
    return w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_ff_module.sv
// rtl/sync_ff_module.sv - multi-stage bit synchronizer, resets to 1
// Ports:
//   i_clk   : system clock
//   i_rst_n : synchronous active-low reset; every stage loads 1
//   i_d     : asynchronous input bit
//   o_q     : synchronized bit (last stage)
module sync_ff_module #(
  parameter int P_SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [P_SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[P_SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = sync_q[P_SYNC_STAGES-1];

endmodule

// File: rtl/rst_key_module.sv
// rtl/rst_key_module.sv - push-button key to fixed-width reset pulse
// Ports:
//   i_clk       : system clock, rising edge
//   i_rst_n     : synchronous active-low reset, highest priority
//   i_key_n     : raw asynchronous key, 0 = pressed
//   o_rst       : active-high reset pulse, P_HOLD_CYCLE clocks per press
//   o_busy      : 1 while the FSM is outside IDLE
//   o_event_cnt : accepted presses since reset, saturating at 255
module rst_key_module
  import rst_pkg::*;
#(
  parameter int P_SYNC_STAGES    = 2,
  parameter int P_DEBOUNCE_CYCLE = 20,
  parameter int P_HOLD_CYCLE     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_key_n,
  output logic                   o_rst,
  output logic                   o_busy,
  output logic [EVENT_CNT_W-1:0] o_event_cnt
);

  localparam int CNT_W = clog2(max_int(P_DEBOUNCE_CYCLE, P_HOLD_CYCLE) + 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(P_DEBOUNCE_CYCLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(P_HOLD_CYCLE);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  rst_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [EVENT_CNT_W-1:0] evt_q, evt_d;
  logic                   rst_q, rst_d;
  logic                   busy_q, busy_d;
  logic                   ks;
  logic                   accept;

  sync_ff_module #(
    .P_SYNC_STAGES(P_SYNC_STAGES)
  ) u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_key_n),
    .o_q    (ks)
  );

  // While debouncing a press, cnt_q holds the number of low samples already
  // taken, so the current low sample completes the window when cnt_q equals
  // P_DEBOUNCE_CYCLE-1. cnt_q is 0 in IDLE, which lets a window of one accept
  // straight from IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    evt_d   = evt_q;
    accept  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!ks) begin
          if (cnt_q == DEB_LAST) begin
            accept = 1'b1;
          end else begin
            state_d = ST_DEB_PRESS;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_DEB_PRESS: begin
        if (ks) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          accept = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_WAIT_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_WAIT_REL: begin
        // Any low sample restarts the release window.
        if (!ks) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (accept) begin
      state_d = ST_HOLD;
      cnt_d   = CNT_ONE;
      if (evt_q != EVENT_CNT_MAX) begin
        evt_d = evt_q + 8'd1;
      end
    end

    // Outputs are decoded from the next state and registered, so they change
    // exactly on the transition edge and never glitch.
    rst_d  = (state_d == ST_HOLD);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      evt_q   <= '0;
      rst_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
      rst_q   <= rst_d;
      busy_q  <= busy_d;
    end
  end

  assign o_rst       = rst_q;
  assign o_busy      = busy_q;
  assign o_event_cnt = evt_q;

endmodule

// File: tb/tb_rst_key_module.sv
// tb/tb_rst_key_module.sv - self-checking bench for rst_key_module
module tb_rst_key_module;

  logic       clk;
  logic       rst_n;
  logic       key;
  logic       key_c;
  logic       rst0, busy0, rst1, busy1;
  logic [7:0] cnt0, cnt1;

  rst_key_module #(
    .P_SYNC_STAGES(2), .P_DEBOUNCE_CYCLE(20), .P_HOLD_CYCLE(16)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_key_n(key),
    .o_rst(rst0), .o_busy(busy0), .o_event_cnt(cnt0)
  );

  rst_key_module #(
    .P_SYNC_STAGES(2), .P_DEBOUNCE_CYCLE(1), .P_HOLD_CYCLE(1)
  ) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_key_n(key_c),
    .o_rst(rst1), .o_busy(busy1), .o_event_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit started  = 0;
  bit rand_c   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: works on run lengths of the delayed key, not on states.
  localparam int PS = 2;
  int deb [2] = '{20, 1};
  int hold[2] = '{16, 1};
  bit hist[2][16];
  int wp[2], nsince[2];
  int low_run[2], high_run[2], hold_left[2], exp_cnt[2];
  bit waiting[2], exp_rst[2], exp_busy[2];

  task automatic model_step(input int i, input bit rn, input bit k);
    bit ks;
    if (!rn) begin
      wp[i] = 0; nsince[i] = 0;
      low_run[i] = 0; high_run[i] = 0; hold_left[i] = 0; exp_cnt[i] = 0;
      waiting[i] = 0; exp_rst[i] = 0; exp_busy[i] = 0;
    end else begin
      // The FSM sees the key value captured PS edges earlier (1 right after reset).
      ks = (nsince[i] >= PS) ? hist[i][(wp[i] + 16 - PS) % 16] : 1'b1;
      hist[i][wp[i]] = k;
      wp[i] = (wp[i] + 1) % 16;
      nsince[i] = nsince[i] + 1;
      if (hold_left[i] > 0) begin
        hold_left[i] = hold_left[i] - 1;
        if (hold_left[i] == 0) begin
          waiting[i] = 1; high_run[i] = 0;
        end
      end else if (waiting[i]) begin
        high_run[i] = ks ? high_run[i] + 1 : 0;
        if (high_run[i] == deb[i]) begin
          waiting[i] = 0; high_run[i] = 0;
        end
      end else begin
        low_run[i] = ks ? 0 : low_run[i] + 1;
        if (low_run[i] == deb[i]) begin
          low_run[i] = 0;
          hold_left[i] = hold[i];
          if (exp_cnt[i] < 255) exp_cnt[i] = exp_cnt[i] + 1;
        end
      end
      exp_rst[i]  = hold_left[i] > 0;
      exp_busy[i] = (hold_left[i] > 0) || waiting[i] || (low_run[i] > 0);
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) started = 1;
    model_step(0, rst_n, key);
    model_step(1, rst_n, key_c);
  end

  // Pulse monitor plus per-cycle compare against the model.
  int  rise[2], width[2], pulses[2];
  bit  prev[2];

  always @(negedge clk) begin
    if (rst0 && !prev[0]) begin rise[0] = cyc; width[0] = 1; pulses[0] = pulses[0] + 1; end
    else if (rst0) width[0] = width[0] + 1;
    if (rst1 && !prev[1]) begin rise[1] = cyc; width[1] = 1; pulses[1] = pulses[1] + 1; end
    else if (rst1) width[1] = width[1] + 1;
    prev[0] = rst0;
    prev[1] = rst1;
    if (started) begin
      chk("o_rst",         int'(rst0),  int'(exp_rst[0]));
      chk("o_busy",        int'(busy0), int'(exp_busy[0]));
      chk("o_event_cnt",   int'(cnt0),  exp_cnt[0]);
      chk("c_o_rst",       int'(rst1),  int'(exp_rst[1]));
      chk("c_o_busy",      int'(busy1), int'(exp_busy[1]));
      chk("c_o_event_cnt", int'(cnt1),  exp_cnt[1]);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rand_c) key_c = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  int e0, p, x, waited;

  initial begin
    rst_n = 1'b0; key = 1'b1; key_c = 1'b1;
    tick(3);
    chk("reset_o_rst",  int'(rst0), 0);
    chk("reset_o_busy", int'(busy0), 0);
    chk("reset_cnt",    int'(cnt0), 0);
    rst_n = 1'b1;

    // Clean press on both instances; the corner instance sees a 1-clock press.
    key = 1'b0; key_c = 1'b0; e0 = cyc + 1;
    tick(1);
    key_c = 1'b1;
    tick(99);
    key = 1'b1;
    tick(60);
    chk("clean_rise_cycle", rise[0], e0 + 21);
    chk("clean_width",      width[0], 16);
    chk("clean_pulses",     pulses[0], 1);
    chk("clean_cnt",        int'(cnt0), 1);
    chk("clean_busy_end",   int'(busy0), 0);
    chk("corner_rise",      rise[1], e0 + 2);
    chk("corner_width",     width[1], 1);
    chk("corner_pulses",    pulses[1], 1);

    // Bounce during press debounce.
    apply_reset();
    p = pulses[0];
    key = 1'b0; tick(10); key = 1'b1; tick(1); key = 1'b0; tick(10); key = 1'b1;
    tick(40);
    chk("bounce_pulses", pulses[0] - p, 0);
    chk("bounce_busy",   int'(busy0), 0);
    chk("bounce_cnt",    int'(cnt0), 0);

    // Release glitch, then a second press.
    apply_reset();
    p = pulses[0];
    key = 1'b0; tick(50); key = 1'b1; tick(8); key = 1'b0; tick(5); key = 1'b1; tick(25);
    key = 1'b0; tick(50); key = 1'b1; tick(60);
    chk("release_pulses", pulses[0] - p, 2);
    chk("release_cnt",    int'(cnt0), 2);

    // Reset during HOLD with the key still held.
    apply_reset();
    p = pulses[0];
    key = 1'b0;
    waited = 0;
    while (!rst0 && waited < 100) begin tick(1); waited = waited + 1; end
    chk("midhold_rise_seen", int'(rst0), 1);
    tick(3);
    rst_n = 1'b0; x = cyc + 1;
    tick(1);
    rst_n = 1'b1;
    chk("midhold_rst_drop", int'(rst0), 0);
    chk("midhold_cnt",      int'(cnt0), 0);
    tick(40);
    chk("retrigger_rise",   rise[0], x + 1 + 21);
    chk("retrigger_pulses", pulses[0] - p, 2);
    chk("retrigger_cnt",    int'(cnt0), 1);
    key = 1'b1; tick(60);

    // Random bouncy key on both instances.
    apply_reset();
    rand_c = 1;
    for (int i = 0; i < 150; i++) begin
      key = ~key;
      tick($urandom_range(1, 35));
    end
    key = 1'b1; tick(60);

    // Saturation: 260 clean presses.
    apply_reset();
    p = pulses[0];
    for (int i = 0; i < 260; i++) begin
      key = 1'b0; tick($urandom_range(21, 30));
      key = 1'b1; tick($urandom_range(40, 50));
    end
    chk("sat_pulses", pulses[0] - p, 260);
    chk("sat_cnt",    int'(cnt0), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
